// File: rtl/uart_secded_pkg.sv
// Shared types and constants for the UART SECDED receive path.
// Hamming(12,8) positions are 1-based; codeword bit i-1 holds position i.
package uart_secded_pkg;

    localparam int unsigned CODE_W = 13;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SYN_W  = 4;
    localparam int unsigned HAM_W  = 12;

    localparam int unsigned PARITY_POS [SYN_W]  = '{1, 2, 4, 8};
    localparam int unsigned DATA_POS   [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_DECODE
    } state_e;

endpackage

// File: rtl/secded_13_8_decode.sv
// Combinational Hamming(12,8)+overall-parity decoder: syndrome, correction and status.
// The syndrome is the XOR of the positions of all set bits, so a single flip points at itself.
module secded_13_8_decode
    import uart_secded_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [DATA_W-1:0] data_c,
    output logic [SYN_W-1:0]  syndrome_c,
    output logic              parity_c,
    output logic              error_detected_c,
    output logic              error_corrected_c,
    output logic              overall_parity_error_c
);

    logic [CODE_W-1:0] corrected;

    always_comb begin
        syndrome_c             = '0;
        parity_c               = ^code;
        corrected              = code;
        error_detected_c       = 1'b0;
        error_corrected_c      = 1'b0;
        overall_parity_error_c = 1'b0;
        data_c                 = '0;

        for (int unsigned pos = 1; pos <= HAM_W; pos++) begin
            if (code[4'(pos - 1)]) begin
                syndrome_c = syndrome_c ^ 4'(pos);
            end
        end

        if (syndrome_c == '0 && !parity_c) begin
            error_detected_c = 1'b0;
        end else if (syndrome_c == '0) begin
            // Only the overall parity bit flipped; Hamming bits are intact.
            error_detected_c       = 1'b1;
            error_corrected_c      = 1'b1;
            overall_parity_error_c = 1'b1;
        end else if (parity_c && syndrome_c <= SYN_W'(HAM_W)) begin
            corrected[syndrome_c - 4'd1] = ~code[syndrome_c - 4'd1];
            error_detected_c             = 1'b1;
            error_corrected_c            = 1'b1;
        end else begin
            error_detected_c = 1'b1;
        end

        for (int unsigned i = 0; i < DATA_W; i++) begin
            data_c[i] = corrected[4'(DATA_POS[i] - 1)];
        end
    end

endmodule

// File: rtl/uart_secded_receiver.sv
// Oversampling UART receiver for 13-bit SECDED codewords; decodes, corrects and
// writes recovered bytes into a wrapping receive memory.
module uart_secded_receiver
    import uart_secded_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_tick,
    input  logic              line,
    output logic [12:0]       data_recorded,
    output logic [7:0]        data_saved_to_memory,
    output logic              data_valid,
    output logic              error_detected,
    output logic              error_corrected,
    output logic              overall_parity_error,
    output logic              framing_error,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = 4;

    state_e              state_q, state_d;
    logic                line_s1_q, line_s1_d;
    logic                line_s2_q, line_s2_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CODE_W-1:0]   shift_q, shift_d;

    logic [CODE_W-1:0]   data_recorded_q, data_recorded_d;
    logic [DATA_W-1:0]   data_saved_q, data_saved_d;
    logic                data_valid_q, data_valid_d;
    logic                error_detected_q, error_detected_d;
    logic                error_corrected_q, error_corrected_d;
    logic                overall_parity_error_q, overall_parity_error_d;
    logic                framing_error_q, framing_error_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic [DATA_W-1:0]   dec_data_c;
    logic [SYN_W-1:0]    dec_syndrome_c;
    logic                dec_parity_c;
    logic                dec_err_det_c;
    logic                dec_err_cor_c;
    logic                dec_ope_c;
    logic                write_ok_c;

    secded_13_8_decode u_decode (
        .code                   (shift_q),
        .data_c                 (dec_data_c),
        .syndrome_c             (dec_syndrome_c),
        .parity_c               (dec_parity_c),
        .error_detected_c       (dec_err_det_c),
        .error_corrected_c      (dec_err_cor_c),
        .overall_parity_error_c (dec_ope_c)
    );

    // Clean frames and correctable single errors are stored; everything else is dropped.
    assign write_ok_c = (dec_syndrome_c == '0) ||
                        (dec_parity_c && dec_syndrome_c <= SYN_W'(HAM_W));

    always_comb begin
        state_d                = state_q;
        line_s1_d              = line;
        line_s2_d              = line_s1_q;
        tick_cnt_d             = tick_cnt_q;
        bit_cnt_d              = bit_cnt_q;
        shift_d                = shift_q;
        data_recorded_d        = data_recorded_q;
        data_saved_d           = data_saved_q;
        data_valid_d           = 1'b0;
        error_detected_d       = error_detected_q;
        error_corrected_d      = error_corrected_q;
        overall_parity_error_d = overall_parity_error_q;
        framing_error_d        = framing_error_q;
        mem_we_d               = 1'b0;
        mem_addr_d             = mem_addr_q;
        mem_wdata_d            = mem_wdata_q;

        // Address holds during the write strobe and advances afterwards.
        if (mem_we_q) begin
            mem_addr_d = mem_addr_q + ADDR_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (baud_tick && !line_s2_q) begin
                    state_d    = ST_START;
                    tick_cnt_d = '0;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    if (tick_cnt_q == TICK_W'(OVERSAMPLE / 2 - 1)) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = line_s2_q ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (tick_cnt_q == TICK_W'(OVERSAMPLE - 1)) begin
                        tick_cnt_d          = '0;
                        shift_d[bit_cnt_q]  = line_s2_q;
                        if (bit_cnt_q == BIT_W'(CODE_W - 1)) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (tick_cnt_q == TICK_W'(OVERSAMPLE - 1)) begin
                        tick_cnt_d = '0;
                        if (line_s2_q) begin
                            state_d = ST_DECODE;
                        end else begin
                            state_d                = ST_IDLE;
                            data_recorded_d        = shift_q;
                            data_valid_d           = 1'b1;
                            error_detected_d       = 1'b1;
                            error_corrected_d      = 1'b0;
                            overall_parity_error_d = 1'b0;
                            framing_error_d        = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
            ST_DECODE: begin
                state_d                = ST_IDLE;
                data_recorded_d        = shift_q;
                data_saved_d           = dec_data_c;
                data_valid_d           = 1'b1;
                error_detected_d       = dec_err_det_c;
                error_corrected_d      = dec_err_cor_c;
                overall_parity_error_d = dec_ope_c;
                framing_error_d        = 1'b0;
                if (write_ok_c) begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = dec_data_c;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q                <= ST_IDLE;
            line_s1_q              <= 1'b1;
            line_s2_q              <= 1'b1;
            tick_cnt_q             <= '0;
            bit_cnt_q              <= '0;
            shift_q                <= '0;
            data_recorded_q        <= '0;
            data_saved_q           <= '0;
            data_valid_q           <= 1'b0;
            error_detected_q       <= 1'b0;
            error_corrected_q      <= 1'b0;
            overall_parity_error_q <= 1'b0;
            framing_error_q        <= 1'b0;
            mem_we_q               <= 1'b0;
            mem_addr_q             <= '0;
            mem_wdata_q            <= '0;
        end else begin
            state_q                <= state_d;
            line_s1_q              <= line_s1_d;
            line_s2_q              <= line_s2_d;
            tick_cnt_q             <= tick_cnt_d;
            bit_cnt_q              <= bit_cnt_d;
            shift_q                <= shift_d;
            data_recorded_q        <= data_recorded_d;
            data_saved_q           <= data_saved_d;
            data_valid_q           <= data_valid_d;
            error_detected_q       <= error_detected_d;
            error_corrected_q      <= error_corrected_d;
            overall_parity_error_q <= overall_parity_error_d;
            framing_error_q        <= framing_error_d;
            mem_we_q               <= mem_we_d;
            mem_addr_q             <= mem_addr_d;
            mem_wdata_q            <= mem_wdata_d;
        end
    end

    assign data_recorded        = data_recorded_q;
    assign data_saved_to_memory = data_saved_q;
    assign data_valid           = data_valid_q;
    assign error_detected       = error_detected_q;
    assign error_corrected      = error_corrected_q;
    assign overall_parity_error = overall_parity_error_q;
    assign framing_error        = framing_error_q;
    assign mem_we               = mem_we_q;
    assign mem_addr             = mem_addr_q;
    assign mem_wdata            = mem_wdata_q;

endmodule

// File: tb/tb_uart_secded_receiver.sv
// Scoreboard bench for uart_secded_receiver: directed frames push expectations,
// a negedge monitor pops and checks them whenever data_valid fires.
module tb_uart_secded_receiver;
    import uart_secded_pkg::*;

    localparam int unsigned OS  = 16;
    localparam int unsigned DIV = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        baud_tick;
    logic        line = 1'b1;
    logic [12:0] data_recorded;
    logic [7:0]  data_saved_to_memory;
    logic        data_valid;
    logic        error_detected;
    logic        error_corrected;
    logic        overall_parity_error;
    logic        framing_error;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [7:0]  mem_wdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [12:0] code;
        logic [7:0]  data;
        bit          chk_data;
        bit          ed, ec, ope, fe, we;
        logic [3:0]  addr;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] exp_addr = 4'd0;
    logic [1:0] div_cnt = 2'd0;

    uart_secded_receiver #(.OVERSAMPLE(OS), .ADDR_W(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .baud_tick            (baud_tick),
        .line                 (line),
        .data_recorded        (data_recorded),
        .data_saved_to_memory (data_saved_to_memory),
        .data_valid           (data_valid),
        .error_detected       (error_detected),
        .error_corrected      (error_corrected),
        .overall_parity_error (overall_parity_error),
        .framing_error        (framing_error),
        .mem_we               (mem_we),
        .mem_addr             (mem_addr),
        .mem_wdata            (mem_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) div_cnt <= (div_cnt == 2'(DIV - 1)) ? 2'd0 : div_cnt + 2'd1;
    assign baud_tick = (div_cnt == 2'(DIV - 1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * DIV) @(negedge clk);
    endtask

    task automatic send_frame(input logic [12:0] code, input logic stop_bit);
        line = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < 13; i++) begin
            line = code[i];
            wait_ticks(OS);
        end
        line = stop_bit;
        wait_ticks(OS);
        line = 1'b1;
        wait_ticks(8);
    endtask

    task automatic push_exp(input logic [12:0] code, input logic [7:0] data, input bit chk_data,
                            input bit ed, input bit ec, input bit ope, input bit fe, input bit we);
        exp_t e;
        e.code = code; e.data = data; e.chk_data = chk_data;
        e.ed = ed; e.ec = ec; e.ope = ope; e.fe = fe; e.we = we;
        e.addr = exp_addr;
        sb.push_back(e);
        if (we) exp_addr = exp_addr + 4'd1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: every data_valid must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("data_recorded", 32'(data_recorded), 32'(e.code));
                    chk("error_detected", 32'(error_detected), 32'(e.ed));
                    chk("error_corrected", 32'(error_corrected), 32'(e.ec));
                    chk("overall_parity_error", 32'(overall_parity_error), 32'(e.ope));
                    chk("framing_error", 32'(framing_error), 32'(e.fe));
                    chk("mem_we", 32'(mem_we), 32'(e.we));
                    if (e.chk_data) chk("data_saved", 32'(data_saved_to_memory), 32'(e.data));
                    if (e.we) begin
                        chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                        chk("mem_wdata", 32'(mem_wdata), 32'(e.data));
                    end
                end
            end else if (mem_we) begin
                chk("mem_we_without_valid", 32'd1, 32'd0);
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(data_valid), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_ed"}, 32'(error_detected), 32'd0);
        chk({tag, "_ec"}, 32'(error_corrected), 32'd0);
        chk({tag, "_ope"}, 32'(overall_parity_error), 32'd0);
        chk({tag, "_fe"}, 32'(framing_error), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_recorded"}, 32'(data_recorded), 32'd0);
        chk({tag, "_saved"}, 32'(data_saved_to_memory), 32'd0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    logic [12:0] wrap_code [3];
    logic [7:0]  wrap_data [3];

    initial begin
        wrap_code[0] = 13'h0A27; wrap_data[0] = 8'hA5;
        wrap_code[1] = 13'h0000; wrap_data[1] = 8'h00;
        wrap_code[2] = 13'h0F77; wrap_data[2] = 8'hFF;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        wait_ticks(4);

        push_exp(13'h0A27, 8'hA5, 1, 0, 0, 0, 0, 1);
        send_frame(13'h0A27, 1'b1);
        drain();
        chk("addr_after_clean", 32'(mem_addr), 32'd1);

        push_exp(13'h0A07, 8'hA5, 1, 1, 1, 0, 0, 1);
        send_frame(13'h0A07, 1'b1);
        drain();

        push_exp(13'h1A27, 8'hA5, 1, 1, 1, 1, 0, 1);
        send_frame(13'h1A27, 1'b1);
        drain();

        push_exp(13'h0807, 8'h00, 0, 1, 0, 0, 0, 0);
        send_frame(13'h0807, 1'b1);
        drain();
        chk("addr_after_double", 32'(mem_addr), 32'd3);

        push_exp(13'h0A27, 8'h00, 0, 1, 0, 0, 1, 0);
        send_frame(13'h0A27, 1'b0);
        wait_ticks(24);
        drain();
        chk("addr_after_framing", 32'(mem_addr), 32'd3);

        line = 1'b0;
        wait_ticks(4);
        line = 1'b1;
        wait_ticks(24);
        chk("false_start_idle", 32'(dut.state_q), 32'(ST_IDLE));
        chk("false_start_no_valid", 32'(sb.size()), 32'd0);

        // Abort in the middle of data bit 7.
        line = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < 7; i++) begin
            line = wrap_code[0][i];
            wait_ticks(OS);
        end
        line = wrap_code[0][7];
        wait_ticks(8);
        rst = 1'b1;
        #1;
        chk_all_zero("midframe_rst");
        @(negedge clk);
        line = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_addr = 4'd0;
        wait_ticks(20);
        chk("post_rst_no_valid", 32'(sb.size()), 32'd0);

        for (int f = 0; f < 16; f++) begin
            push_exp(wrap_code[f % 3], wrap_data[f % 3], 1, 0, 0, 0, 0, 1);
            send_frame(wrap_code[f % 3], 1'b1);
            drain();
        end
        chk("addr_wrapped", 32'(mem_addr), 32'd0);

        wait_ticks(10);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
